// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap sequencer at the MW end of the pipe.
//
// Answers CSR reads combinationally, commits CSR writes, accepts timer and
// external interrupts, executes mret and drives the fetch redirect.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   stall        MW stage frozen; only mcycle keeps advancing
//   csr_reg_rdMW CSR read in MW (the read path is unconditional)
//   csr_reg_wrMW CSR write in MW
//   is_mretMW    mret in MW
//   csr_addr     CSR address
//   csr_wdata    CSR write data (full-word writes)
//   pcMW         PC of the MW-stage instruction (becomes mepc on a trap)
//   timer_irq    level timer interrupt
//   ext_irq      level external interrupt
//   csr_rdata    read data for csr_addr
//   redirect     fetch redirect this cycle
//   redirect_pc  redirect target (trap vector or mepc)
//   trap_taken   interrupt accepted this cycle
module csr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        csr_reg_rdMW,
  input  logic        csr_reg_wrMW,
  input  logic        is_mretMW,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] pcMW,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_taken
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
  localparam logic [11:0] ADDR_MHARTID = 12'hF14;

  localparam logic [4:0] CODE_EXT   = 5'd11;
  localparam logic [4:0] CODE_TIMER = 5'd7;

  // Architectural state; only the writable bits of mstatus/mie exist.
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic        mie_meie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [63:0] mcycle;

  logic        irq_ext;
  logic        irq_timer;
  logic        irq_p;
  logic [4:0]  cause_code;
  logic [31:0] vector_base;
  logic [31:0] trap_pc;
  logic        wr_en;
  logic        mret_go;

  // The read enable only matters to the pipeline; the read path is always live.
  logic        unused_rd;
  assign unused_rd = csr_reg_rdMW;

  assign irq_ext    = mstatus_mie & mie_meie & ext_irq;
  assign irq_timer  = mstatus_mie & mie_mtie & timer_irq;
  assign irq_p      = irq_ext | irq_timer;
  // External wins over timer when both are pending.
  assign cause_code = irq_ext ? CODE_EXT : CODE_TIMER;

  // A CSR write or mret in MW holds the interrupt off for one cycle so the
  // accept always sees the post-write / post-mret MIE.
  assign trap_taken = irq_p & ~stall & ~is_mretMW & ~csr_reg_wrMW & rst_n;
  assign mret_go    = is_mretMW & ~stall & rst_n;
  assign wr_en      = csr_reg_wrMW & ~stall;
  assign redirect   = trap_taken | mret_go;

  // Mode 1 is vectored; modes 0, 2 and 3 all jump to the base.
  assign vector_base = {mtvec[31:2], 2'b00};
  assign trap_pc     = (mtvec[1:0] == 2'b01)
                       ? vector_base + {25'b0, cause_code, 2'b00}
                       : vector_base;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    redirect_pc = 32'h0;
    if (trap_taken) begin
      redirect_pc = trap_pc;
    end else if (mret_go) begin
      redirect_pc = mepc;
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'h0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MIE:     csr_rdata = {20'h0, mie_meie, 3'b0, mie_mtie, 7'b0};
      ADDR_MIP:     csr_rdata = {20'h0, ext_irq, 3'b0, timer_irq, 7'b0};
      ADDR_MTVEC:   csr_rdata = mtvec;
      ADDR_MEPC:    csr_rdata = mepc;
      ADDR_MCAUSE:  csr_rdata = mcause;
      ADDR_MCYCLE:  csr_rdata = mcycle[31:0];
      ADDR_MCYCLEH: csr_rdata = mcycle[63:32];
      ADDR_MHARTID: csr_rdata = HART_ID;
      default:      csr_rdata = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is checked first and synchronously, so it overrides any
    // write, trap or mret presented on the same edge.
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RST;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      mcycle       <= 64'h0;
    end else begin
      // mcycle runs through stalls; a write to either half replaces that half
      // and swallows the increment for that edge.
      if (wr_en && csr_addr == ADDR_MCYCLE) begin
        mcycle[31:0] <= csr_wdata;
      end else if (wr_en && csr_addr == ADDR_MCYCLEH) begin
        mcycle[63:32] <= csr_wdata;
      end else begin
        mcycle <= mcycle + 64'd1;
      end

      if (!stall) begin
        if (trap_taken) begin
          mepc         <= pcMW;
          mcause       <= {1'b1, 26'b0, cause_code};
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
        end else begin
          if (csr_reg_wrMW) begin
            case (csr_addr)
              ADDR_MSTATUS: begin
                mstatus_mie  <= csr_wdata[3];
                mstatus_mpie <= csr_wdata[7];
              end
              ADDR_MIE: begin
                mie_mtie <= csr_wdata[7];
                mie_meie <= csr_wdata[11];
              end
              ADDR_MTVEC:  mtvec  <= csr_wdata;
              ADDR_MEPC:   mepc   <= {csr_wdata[31:2], 2'b00};
              ADDR_MCAUSE: mcause <= csr_wdata;
              default: ;
            endcase
          end
          // mret wins over a simultaneous mstatus write.
          if (is_mretMW) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed self-checking bench for csr_unit.
// Inputs change 1 ns after each rising edge; outputs are sampled before the
// next rising edge.
module tb_csr_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
  localparam logic [31:0] HART_ID   = 32'h0000_0007;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        csr_reg_rdMW;
  logic        csr_reg_wrMW;
  logic        is_mretMW;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] pcMW;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap_taken;

  int tests  = 0;
  int failed = 0;
  int exp_cyc = 0;

  csr_unit #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .csr_reg_rdMW (csr_reg_rdMW),
    .csr_reg_wrMW (csr_reg_wrMW),
    .is_mretMW    (is_mretMW),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .pcMW         (pcMW),
    .timer_irq    (timer_irq),
    .ext_irq      (ext_irq),
    .csr_rdata    (csr_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .trap_taken   (trap_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_cyc++;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_reg_wrMW = 1'b1;
    csr_addr     = a;
    csr_wdata    = d;
    step();
    csr_reg_wrMW = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; csr_reg_rdMW = 1'b1; csr_reg_wrMW = 1'b0;
    is_mretMW = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0; pcMW = 32'h0;
    timer_irq = 1'b0; ext_irq = 1'b0;

    // Reset: outputs gated even with mret presented.
    step();
    step();
    is_mretMW = 1'b1;
    #1;
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_trap_taken", {31'b0, trap_taken}, 32'h0);
    is_mretMW = 1'b0;

    // Release reset right after the last reset edge; mcycle was 0 there.
    rst_n = 1'b1;
    exp_cyc = 0;
    rd(12'h300, 32'h0, "rst_mstatus");
    step();
    rd(12'h305, MTVEC_RST, "rst_mtvec");
    step();
    rd(12'hB00, 32'd2, "mcycle_2");
    step();
    rd(12'hB00, 32'd3, "mcycle_3");
    rd(12'hB80, 32'h0, "mcycleh_0");
    rd(12'hF14, HART_ID, "mhartid");

    // Vectored trap, external wins over timer.
    wr(12'h305, 32'h0000_1001);
    wr(12'h304, 32'h0000_0880);
    wr(12'h300, 32'h0000_0008);
    ext_irq = 1'b1; timer_irq = 1'b1; pcMW = 32'h40;
    #1;
    check("trap1_taken", {31'b0, trap_taken}, 32'h1);
    check("trap1_redirect", {31'b0, redirect}, 32'h1);
    check("trap1_pc", redirect_pc, 32'h0000_102C);
    step();
    check("trap1_one_cycle", {31'b0, trap_taken}, 32'h0);
    rd(12'h342, 32'h8000_000B, "trap1_mcause");
    rd(12'h341, 32'h0000_0040, "trap1_mepc");
    rd(12'h300, 32'h0000_0080, "trap1_mstatus");

    // mret, then the still-pending irq is taken on the following cycle.
    is_mretMW = 1'b1;
    #1;
    check("mret_redirect", {31'b0, redirect}, 32'h1);
    check("mret_pc", redirect_pc, 32'h0000_0040);
    check("mret_no_trap", {31'b0, trap_taken}, 32'h0);
    step();
    is_mretMW = 1'b0; pcMW = 32'h44;
    rd(12'h300, 32'h0000_0088, "mret_mstatus");
    check("retrap_taken", {31'b0, trap_taken}, 32'h1);
    check("retrap_pc", redirect_pc, 32'h0000_102C);
    step();
    rd(12'h341, 32'h0000_0044, "retrap_mepc");

    // Deferral by a CSR write, then by two stalled cycles.
    ext_irq = 1'b0;
    is_mretMW = 1'b1;
    step();
    is_mretMW = 1'b0;
    csr_reg_wrMW = 1'b1; csr_addr = 12'h7C0; csr_wdata = 32'hFFFF_FFFF;
    #1;
    check("defer_wr", {31'b0, trap_taken}, 32'h0);
    step();
    csr_reg_wrMW = 1'b0; stall = 1'b1; is_mretMW = 1'b1;
    #1;
    check("defer_stall1", {31'b0, trap_taken}, 32'h0);
    check("stall_mret_redirect", {31'b0, redirect}, 32'h0);
    step();
    is_mretMW = 1'b0;
    csr_reg_wrMW = 1'b1; csr_addr = 12'h341; csr_wdata = 32'hDEAD_BEEC;
    #1;
    check("defer_stall2", {31'b0, trap_taken}, 32'h0);
    step();
    csr_reg_wrMW = 1'b0; stall = 1'b0; pcMW = 32'h80;
    rd(12'h341, 32'h0000_0044, "stall_wr_ignored");
    rd(12'hB00, exp_cyc, "mcycle_thru_stall");
    check("defer_fire", {31'b0, trap_taken}, 32'h1);
    check("timer_pc", redirect_pc, 32'h0000_101C);
    step();
    rd(12'h342, 32'h8000_0007, "timer_mcause");
    rd(12'h341, 32'h0000_0080, "timer_mepc");

    // 64-bit mcycle wrap.
    timer_irq = 1'b0;
    wr(12'hB00, 32'hFFFF_FFFF);
    csr_reg_wrMW = 1'b1; csr_addr = 12'hB80; csr_wdata = 32'hFFFF_FFFF;
    #1;
    check("rd_old_on_wr", csr_rdata, 32'h0);
    step();
    csr_reg_wrMW = 1'b0;
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_max_lo");
    rd(12'hB80, 32'hFFFF_FFFF, "mcycle_max_hi");
    step();
    rd(12'hB00, 32'h0, "wrap_lo");
    rd(12'hB80, 32'h0, "wrap_hi");
    wr(12'hF14, 32'h0000_0099);
    rd(12'hF14, HART_ID, "mhartid_ro");

    // Masking and read-only / unimplemented addresses.
    wr(12'h341, 32'h0000_0123);
    rd(12'h341, 32'h0000_0120, "mepc_align");
    rd(12'h7C0, 32'h0, "unimpl_read");
    timer_irq = 1'b1;
    rd(12'h344, 32'h0000_0080, "mip_timer");
    ext_irq = 1'b1;
    rd(12'h344, 32'h0000_0880, "mip_both");
    ext_irq = 1'b0; timer_irq = 1'b0;
    wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, 32'h0000_0088, "mstatus_mask");
    wr(12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0880, "mie_mask");

    // Mode 3 stored but behaves as direct.
    wr(12'h305, 32'h0000_2003);
    rd(12'h305, 32'h0000_2003, "mtvec_mode3");
    timer_irq = 1'b1; pcMW = 32'h200;
    #1;
    check("direct_taken", {31'b0, trap_taken}, 32'h1);
    check("direct_pc", redirect_pc, 32'h0000_2000);
    step();
    is_mretMW = 1'b1;
    #1;
    check("mret2_pc", redirect_pc, 32'h0000_0200);
    step();
    is_mretMW = 1'b0;

    // Reset arrives while a trap and a write are both pending.
    rst_n = 1'b0; pcMW = 32'h300;
    csr_reg_wrMW = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h0000_5550;
    #1;
    check("midrst_trap", {31'b0, trap_taken}, 32'h0);
    check("midrst_redirect", {31'b0, redirect}, 32'h0);
    check("midrst_pc", redirect_pc, 32'h0);
    step();
    csr_reg_wrMW = 1'b0;
    rd(12'h341, 32'h0, "midrst_mepc");
    rd(12'h342, 32'h0, "midrst_mcause");
    rd(12'h300, 32'h0, "midrst_mstatus");
    rd(12'h304, 32'h0, "midrst_mie");
    step();
    rd(12'h305, MTVEC_RST, "midrst_mtvec");
    rd(12'hB00, 32'h0, "midrst_mcycle");
    rd(12'hB80, 32'h0, "midrst_mcycleh");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
